// File: rtl/path_bucket_parser.sv
// Unpacks ORAM path buckets (header + ORAMZ blocks) and streams real blocks to the Stash write port.
// Build option ORAM_DUMMY_FORWARD_EN: forward dummy slots too, tagged with the all-ones dummy address.
//   state     | meaning
//   StIdle    | waiting for StartPath
//   StHeader  | collecting bucket header chunks into headerReg
//   StForward | passing current slot's chunks to the Stash
//   StDrain   | discarding chunks of a dummy slot
//   StDone    | one-cycle PathDone pulse
module path_bucket_parser #(
    parameter int DataWidth = 64,
    parameter int ORAMB     = 512,
    parameter int ORAMU     = 32,
    parameter int ORAML     = 32,
    parameter int ORAMZ     = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 StartPath,
    output logic                 Busy,
    input  logic [DataWidth-1:0] InData,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [DataWidth-1:0] WriteData,
    output logic [ORAMU-1:0]     WritePAddr,
    output logic [ORAML-1:0]     WriteLeaf,
    output logic                 WriteInValid,
    input  logic                 WriteInReady,
    output logic                 PathDone,
    output logic [7:0]           RealBlockCount
);

    localparam int BlockChunks  = ORAMB / DataWidth;
    localparam int HeaderBits   = ORAMZ * (1 + ORAMU + ORAML);
    localparam int HeaderChunks = (HeaderBits + DataWidth - 1) / DataWidth;
    localparam int MaxChunks    = (HeaderChunks > BlockChunks) ? HeaderChunks : BlockChunks;
    localparam int ChunkW       = (MaxChunks > 1) ? $clog2(MaxChunks) : 1;
    localparam int SlotW        = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
    localparam int BucketW      = $clog2(ORAML + 2);
    localparam int LeafBase     = ORAMZ + ORAMZ * ORAMU;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StForward,
        StDrain,
        StDone
    } state_t;

    state_t                state, nextState;
    logic [BucketW-1:0]    bucketCnt;
    logic [SlotW-1:0]      slotCnt;
    logic [ChunkW-1:0]     chunkCnt;
    logic [HeaderBits-1:0] headerReg;
    logic                  curReal;

    logic                  accept;
    logic                  lastChunk;
    logic                  slotEnd;
    logic                  pathEnd;
    logic                  doDispatch;
    logic [HeaderBits-1:0] hdrNext;
    logic [HeaderBits-1:0] dispHdr;
    logic [SlotW-1:0]      dispSlot;
    logic                  dispValid;
    logic                  dispReal;
    logic [ORAMU-1:0]      dispPAddr;
    logic [ORAML-1:0]      dispLeaf;
    state_t                dispTarget;

    // Padding bits beyond HeaderBits in the last header chunk are simply not stored.
    always_comb begin
        hdrNext = headerReg;
        for (int b = 0; b < DataWidth; b++) begin
            if (int'(chunkCnt) * DataWidth + b < HeaderBits)
                hdrNext[int'(chunkCnt) * DataWidth + b] = InData[b];
        end
    end

    // Slot 0 is dispatched from the header being completed this cycle, so the
    // first block can start right after the last header chunk.
    always_comb begin
        dispHdr   = (state == StHeader) ? hdrNext : headerReg;
        dispSlot  = (state == StHeader) ? '0 : slotCnt + SlotW'(1);
        dispValid = dispHdr[int'(dispSlot)];
        dispPAddr = dispHdr[ORAMZ + int'(dispSlot) * ORAMU +: ORAMU];
        dispLeaf  = dispHdr[LeafBase + int'(dispSlot) * ORAML +: ORAML];
        dispReal  = dispValid;
`ifdef ORAM_DUMMY_FORWARD_EN
        dispTarget = StForward;
        if (!dispValid) begin
            dispPAddr = '1;
            dispLeaf  = '0;
        end
`else
        dispTarget = dispValid ? StForward : StDrain;
`endif
    end

    always_comb begin
        InReady = 1'b0;
        case (state)
            StHeader:  InReady = 1'b1;
            StDrain:   InReady = 1'b1;
            StForward: InReady = WriteInReady;
            default:   InReady = 1'b0;
        endcase
        accept       = InValid & InReady;
        lastChunk    = (state == StHeader) ? (chunkCnt == ChunkW'(HeaderChunks - 1))
                                           : (chunkCnt == ChunkW'(BlockChunks - 1));
        slotEnd      = (slotCnt == SlotW'(ORAMZ - 1));
        pathEnd      = (bucketCnt == BucketW'(ORAML));
        Busy         = (state != StIdle);
        PathDone     = (state == StDone);
        WriteInValid = (state == StForward) & InValid;
        WriteData    = InData;
    end

    always_comb begin
        nextState  = state;
        doDispatch = 1'b0;
        case (state)
            StIdle: begin
                if (StartPath) nextState = StHeader;
            end
            StHeader: begin
                if (accept && lastChunk) begin
                    doDispatch = 1'b1;
                    nextState  = dispTarget;
                end
            end
            StForward, StDrain: begin
                if (accept && lastChunk) begin
                    if (slotEnd) begin
                        nextState = pathEnd ? StDone : StHeader;
                    end else begin
                        doDispatch = 1'b1;
                        nextState  = dispTarget;
                    end
                end
            end
            StDone:  nextState = StIdle;
            default: nextState = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= StIdle;
            bucketCnt      <= '0;
            slotCnt        <= '0;
            chunkCnt       <= '0;
            headerReg      <= '0;
            curReal        <= 1'b0;
            WritePAddr     <= '0;
            WriteLeaf      <= '0;
            RealBlockCount <= '0;
        end else begin
            state <= nextState;
            if (state == StIdle && StartPath) begin
                bucketCnt      <= '0;
                slotCnt        <= '0;
                chunkCnt       <= '0;
                RealBlockCount <= '0;
            end
            if (accept) begin
                chunkCnt <= lastChunk ? '0 : chunkCnt + ChunkW'(1);
                if (state == StHeader) headerReg <= hdrNext;
                if (lastChunk && state != StHeader) begin
                    if (state == StForward && curReal && RealBlockCount != 8'hFF)
                        RealBlockCount <= RealBlockCount + 8'd1;
                    if (slotEnd) begin
                        slotCnt   <= '0;
                        bucketCnt <= bucketCnt + BucketW'(1);
                    end else begin
                        slotCnt <= slotCnt + SlotW'(1);
                    end
                end
            end
            if (doDispatch) begin
                WritePAddr <= dispPAddr;
                WriteLeaf  <= dispLeaf;
                curReal    <= dispReal;
            end
        end
    end

endmodule

// File: tb/tb_path_bucket_parser.sv
// Directed bench for path_bucket_parser at default parameters: scenario table plus reset/StartPath corner sequences.
module tb_path_bucket_parser;

    localparam int DW     = 64;
    localparam int NB     = 33;
    localparam int HC     = 5;
    localparam int BC     = 8;
    localparam int Z      = 4;
    localparam int BUCKET = HC + Z * BC;
    localparam int N      = NB * BUCKET;
`ifdef ORAM_DUMMY_FORWARD_EN
    localparam bit DummyFwd = 1'b1;
`else
    localparam bit DummyFwd = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          StartPath = 1'b0;
    logic          Busy;
    logic [DW-1:0] InData = '0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [DW-1:0] WriteData;
    logic [31:0]   WritePAddr;
    logic [31:0]   WriteLeaf;
    logic          WriteInValid;
    logic          WriteInReady = 1'b1;
    logic          PathDone;
    logic [7:0]    RealBlockCount;

    path_bucket_parser dut (
        .Clock(Clock), .Reset(Reset), .StartPath(StartPath), .Busy(Busy),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .WriteData(WriteData), .WritePAddr(WritePAddr), .WriteLeaf(WriteLeaf),
        .WriteInValid(WriteInValid), .WriteInReady(WriteInReady),
        .PathDone(PathDone), .RealBlockCount(RealBlockCount)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    logic [63:0] sData  [N];
    bit          sFwd   [N];
    logic [31:0] sPAddr [N];
    logic [31:0] sLeaf  [N];

    typedef struct {
        logic [3:0] vpat;
        int         rdyMode;
        bit         gap;
        int         expChunks;
        int         expReal;
        int         expCycle;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Path stream: per bucket a header then 4 blocks of counter-valued chunks.
    task automatic buildStream(input logic [3:0] vpat);
        logic [319:0] h;
        int p;
        int n;
        p = 0;
        for (int b = 0; b < NB; b++) begin
            h = '0;
            h[3:0] = vpat;
            for (int s = 0; s < Z; s++) begin
                n = b * Z + s;
                h[4 + s * 32 +: 32]   = 32'hf000_0000 + 32'(n);
                h[132 + s * 32 +: 32] = {16'(n), 16'hffff};
            end
            for (int c = 0; c < HC; c++) begin
                sData[p] = h[c * 64 +: 64];
                sFwd[p]  = 1'b0;
                sPAddr[p] = '0;
                sLeaf[p]  = '0;
                p++;
            end
            for (int s = 0; s < Z; s++) begin
                n = b * Z + s;
                for (int c = 0; c < BC; c++) begin
                    sData[p]  = 64'hd000_0000_0000_0000 + 64'(p);
                    sFwd[p]   = vpat[s] | DummyFwd;
                    sPAddr[p] = vpat[s] ? 32'hf000_0000 + 32'(n) : 32'hffff_ffff;
                    sLeaf[p]  = vpat[s] ? {16'(n), 16'hffff} : 32'h0;
                    p++;
                end
            end
        end
    endtask

    task automatic runPath(input int rdyMode, input bit gap, input int pulseAt, input int abortAt,
                           output int errs, output int fwdChunks, output int dones, output int doneCycle);
        int ptr;
        int post;
        bit pulsed;
        logic expRdy;
        logic expWv;
        ptr = 0; post = -1; pulsed = 1'b0;
        errs = 0; fwdChunks = 0; dones = 0; doneCycle = -1;
        @(negedge Clock);
        StartPath = 1'b1;
        InValid = 1'b0;
        WriteInReady = 1'b1;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge Clock);
            StartPath = 1'b0;
            if (ptr == abortAt) break;
            if (ptr == pulseAt && !pulsed) begin
                StartPath = 1'b1;
                pulsed = 1'b1;
            end
            if (ptr < N) begin
                InData  = sData[ptr];
                InValid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                InData  = '0;
                InValid = 1'b0;
            end
            WriteInReady = (rdyMode == 0) ? 1'b1 : (k % 3 == 0);
            #1;
            expRdy = (ptr < N) ? (sFwd[ptr] ? WriteInReady : 1'b1) : 1'b0;
            expWv  = (ptr < N) && InValid && sFwd[ptr];
            if (InReady !== expRdy || WriteInValid !== expWv || WriteData !== InData) begin
                if (errs < 3) $display("note: handshake off at chunk %0d rdy=%b wv=%b", ptr, InReady, WriteInValid);
                errs++;
            end
            if (WriteInValid === 1'b1 && WriteInReady && ptr < N) begin
                fwdChunks++;
                if (WritePAddr !== sPAddr[ptr] || WriteLeaf !== sLeaf[ptr]) begin
                    if (errs < 3) $display("note: tag off at chunk %0d paddr=%h leaf=%h", ptr, WritePAddr, WriteLeaf);
                    errs++;
                end
            end
            if (PathDone === 1'b1) begin
                dones++;
                if (doneCycle < 0) begin
                    doneCycle = k;
                    post = 0;
                end
            end
            if (InValid && InReady === 1'b1 && ptr < N) ptr++;
            if (post >= 0) begin
                if (post == 3) break;
                post++;
            end
        end
        StartPath = 1'b0;
    endtask

    initial begin
        int errs, fwdChunks, dones, doneCycle;

        vecs[0] = '{4'hF, 0, 1'b0, 1056, 132, 1222};
        vecs[1] = '{4'h5, 0, 1'b0, DummyFwd ? 1056 : 528, 66, 1222};
        vecs[2] = '{4'hF, 1, 1'b1, 1056, 132, 0};
        vecs[3] = '{4'h5, 1, 1'b1, DummyFwd ? 1056 : 528, 66, 0};
        vecs[4] = '{4'h0, 0, 1'b0, DummyFwd ? 1056 : 0, 0, 1222};

        repeat (3) @(negedge Clock);
        InValid = 1'b1;
        WriteInReady = 1'b1;
        #1;
        check("rst Busy", 64'(Busy), 0);
        check("rst InReady", 64'(InReady), 0);
        check("rst WriteInValid", 64'(WriteInValid), 0);
        check("rst PathDone", 64'(PathDone), 0);
        check("rst RealBlockCount", 64'(RealBlockCount), 0);
        check("rst WritePAddr", 64'(WritePAddr), 0);
        check("rst WriteLeaf", 64'(WriteLeaf), 0);
        @(negedge Clock);
        Reset = 1'b0;
        InValid = 1'b0;
        #1;
        check("idle InReady", 64'(InReady), 0);

        for (int i = 0; i < 5; i++) begin
            buildStream(vecs[i].vpat);
            runPath(vecs[i].rdyMode, vecs[i].gap, -1, -1, errs, fwdChunks, dones, doneCycle);
            check($sformatf("s%0d stream errors", i), 64'(errs), 0);
            check($sformatf("s%0d forwarded chunks", i), 64'(fwdChunks), 64'(vecs[i].expChunks));
            check($sformatf("s%0d PathDone pulses", i), 64'(dones), 1);
            check($sformatf("s%0d RealBlockCount", i), 64'(RealBlockCount), 64'(vecs[i].expReal));
            check($sformatf("s%0d Busy after", i), 64'(Busy), 0);
            if (vecs[i].expCycle != 0)
                check($sformatf("s%0d done cycle", i), 64'(doneCycle), 64'(vecs[i].expCycle));
        end

        // Reset in the middle of slot 0 of bucket 5 (chunk 193).
        buildStream(4'hF);
        runPath(0, 1'b0, -1, 5 * BUCKET + HC + 3, errs, fwdChunks, dones, doneCycle);
        #1;
        check("abort stream errors", 64'(errs), 0);
        check("abort no PathDone", 64'(dones), 0);
        check("abort Busy before", 64'(Busy), 1);
        check("abort count before", 64'(RealBlockCount), 20);
        Reset = 1'b1;
        InValid = 1'b1;
        WriteInReady = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("abort Busy", 64'(Busy), 0);
        check("abort InReady", 64'(InReady), 0);
        check("abort WriteInValid", 64'(WriteInValid), 0);
        check("abort PathDone", 64'(PathDone), 0);
        check("abort RealBlockCount", 64'(RealBlockCount), 0);
        check("abort WritePAddr", 64'(WritePAddr), 0);
        check("abort WriteLeaf", 64'(WriteLeaf), 0);
        InValid = 1'b0;
        runPath(0, 1'b0, -1, -1, errs, fwdChunks, dones, doneCycle);
        check("fresh stream errors", 64'(errs), 0);
        check("fresh PathDone pulses", 64'(dones), 1);
        check("fresh done cycle", 64'(doneCycle), 1222);
        check("fresh RealBlockCount", 64'(RealBlockCount), 132);

        // StartPath pulsed while forwarding a block of bucket 13.
        runPath(0, 1'b0, 500, -1, errs, fwdChunks, dones, doneCycle);
        check("restart stream errors", 64'(errs), 0);
        check("restart PathDone pulses", 64'(dones), 1);
        check("restart done cycle", 64'(doneCycle), 1222);
        check("restart RealBlockCount", 64'(RealBlockCount), 132);
        check("restart forwarded chunks", 64'(fwdChunks), 1056);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/path_bucket_parser.md
# path_bucket_parser

Upstream feeder for the Stash write port. Consumes the raw path stream returned by the backend: ORAML+1 buckets, each a bucket header followed by ORAMZ data blocks. It unpacks each header into per-slot valid/PAddr/Leaf fields and forwards real blocks chunk-by-chunk onto the Stash WriteData/WritePAddr/WriteLeaf/WriteInValid handshake. Dummy blocks are drained without reaching the stash.

## Interface
- DataWidth, 64, chunk width in bits
- ORAMB, 512, block size in bits; BlockChunks = ORAMB/DataWidth (integer, ≥1)
- ORAMU, 32, PAddr width
- ORAML, 32, leaf width; path length = ORAML+1 buckets
- ORAMZ, 4, blocks per bucket
- Derived: HeaderBits = ORAMZ*(1+ORAMU+ORAML); HeaderChunks = ceil(HeaderBits/DataWidth)
- Clock  in  1  sole clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- StartPath  in  1  one-cycle pulse, begins a path; ignored unless Idle
- Busy  out  1  high in any state other than Idle
- InData  in  DataWidth  backend chunk
- InValid  in  1  InData valid
- InReady  out  1  chunk accepted when InValid & InReady
- WriteData  out  DataWidth  equals InData
- WritePAddr  out  ORAMU  PAddr of current slot
- WriteLeaf  out  ORAML  Leaf of current slot
- WriteInValid  out  1  to Stash
- WriteInReady  in  1  from Stash
- PathDone  out  1  one-cycle pulse after last chunk of last bucket
- RealBlockCount  out  8  real blocks forwarded in current/last path

## Operation
- Header layout (chunk 0 first, LSB first, zero-padded): bits [ORAMZ-1:0] valid; next ORAMZ*ORAMU PAddrs (slot 0 lowest); next ORAMZ*ORAML Leaves (slot 0 lowest).
- States: Idle, Header, Forward, Drain, Done.
- Idle: StartPath -> Header; BucketCnt, SlotCnt, ChunkCnt, RealBlockCount cleared.
- Header: accept HeaderChunks chunks into HeaderReg at ChunkCnt position; on last accept -> slot 0 dispatch.
- Slot dispatch: valid[SlotCnt]=1 -> Forward, else Drain (see Configuration).
- Forward/Drain: accept BlockChunks chunks; on last accept: real block -> RealBlockCount+1 (saturate 255); SlotCnt==ORAMZ-1 -> (BucketCnt==ORAML ? Done : Header, BucketCnt+1), else SlotCnt+1 and dispatch next slot.
- Done: PathDone=1 for one cycle -> Idle.
- Counters: ChunkCnt wraps to 0 at end of each header/block; SlotCnt wraps at ORAMZ; no carry across buckets.

## Timing
- Reset: state Idle, Busy=0, InReady=0, WriteInValid=0, PathDone=0, RealBlockCount=0, WritePAddr=0, WriteLeaf=0, HeaderReg=0.
- InReady: Idle/Done 0; Header 1; Drain 1; Forward = WriteInReady.
- WriteInValid = InValid in Forward, else 0. WriteData combinational pass-through of InData; zero added latency, no buffering.
- WritePAddr/WriteLeaf registered from HeaderReg at slot dispatch; stable for whole block.
- Header-to-first-forward: 0 idle cycles; next slot's chunk may be accepted the cycle after previous block's last chunk.
- Backpressure: InValid low or WriteInReady low stalls Forward with all counters held.
- Minimum path duration: (ORAML+1)*(HeaderChunks+ORAMZ*BlockChunks) accepted chunks + 1 Done cycle.
- Reset mid-path: immediate return to Idle, partial block abandoned, no PathDone.
- StartPath while Busy: ignored, no effect on counters.

## Configuration
- ORAM_DUMMY_FORWARD_EN defined: invalid slots also go to Forward with WritePAddr = all ones (DummyBlockAddress), WriteLeaf = 0; not counted in RealBlockCount.
- Undefined: invalid slots go to Drain; consumed at one chunk/cycle, never presented to Stash.

## Test plan
- Defaults, one path, all slots valid, PAddr f0000000+n, Leaf 0000ffff, InData counter, WriteInReady=1 -> 132 forwarded blocks of 8 chunks, WriteData sequence contiguous minus header chunks, RealBlockCount=132, PathDone once.
- Bucket valid=4'b0101 all buckets, macro undefined -> only slots 0,2 reach Stash (66 blocks), drained chunks never raise WriteInValid, RealBlockCount=66.
- Same with ORAM_DUMMY_FORWARD_EN -> 132 blocks, slots 1,3 carry PAddr ffffffff, RealBlockCount=66.
- WriteInReady toggling 1-of-3 plus random InValid gaps -> no chunk lost/duplicated, PAddr/Leaf stable within each block.
- Reset asserted mid-block of bucket 5 -> next cycle Idle, all outputs at reset values; fresh StartPath completes normally.
- StartPath pulsed during Forward -> ignored; single PathDone at expected chunk count.
